// File: rtl/jtdsp16_dau_ctrl.sv
// jtdsp16_dau_ctrl: DAU instruction sequencer with condition evaluation, counters and heads/tails LFSR
module jtdsp16_dau_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'h0001
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  input  logic        lmi,
  input  logic        leq,
  input  logic        llv,
  input  logic        lmv,
  input  logic [1:0]  c_wr,
  input  logic [7:0]  c_din,
  output logic        inst_ack,
  output logic        busy,
  output logic [4:0]  t_field,
  output logic [3:0]  f1_field,
  output logic [3:0]  f2_field,
  output logic        s_field,
  output logic        d_field,
  output logic [4:0]  c_field,
  output logic        dau_en,
  output logic        cond_true,
  output logic [7:0]  c0,
  output logic [7:0]  c1,
  output logic [7:0]  c2
);
  typedef enum logic [1:0] {IDLE, DEC, EXEC} state_t;
  state_t st, st_nx;
  logic [15:0] lfsr;
  logic is_cond, cond_eval, c0_inc, c1_inc, ifc_exec, lfsr_step;
  assign is_cond   = t_field[4:1] == 4'b1001;
  assign c0_inc    = st == DEC && is_cond && c_field[4:1] == 4'd5;
  assign c1_inc    = st == DEC && is_cond && c_field[4:1] == 4'd6;
  assign lfsr_step = st == DEC && is_cond && c_field[4:1] == 4'd4;
  assign ifc_exec  = st == EXEC && t_field == 5'h13;
  always_comb begin
    cond_eval = 1'b0;
    case (c_field)
      5'd0:  cond_eval = lmi;
      5'd1:  cond_eval = !lmi;
      5'd2:  cond_eval = leq;
      5'd3:  cond_eval = !leq;
      5'd4:  cond_eval = llv;
      5'd5:  cond_eval = !llv;
      5'd6:  cond_eval = lmv;
      5'd7:  cond_eval = !lmv;
      5'd8:  cond_eval = lfsr[0];
      5'd9:  cond_eval = !lfsr[0];
      5'd10: cond_eval = !c0[7];
      5'd11: cond_eval = c0[7];
      5'd12: cond_eval = !c1[7];
      5'd13: cond_eval = c1[7];
      5'd14: cond_eval = 1'b1;
      5'd16: cond_eval = !lmi && !leq;
      5'd17: cond_eval = lmi || leq;
      default: cond_eval = 1'b0;
    endcase
  end
  // strobes are gated by rst so an aborted instruction never fires
  always_comb begin
    st_nx    = !cen ? st : st == IDLE ? (inst_valid ? DEC : IDLE) : st == DEC ? EXEC : IDLE;
    inst_ack = cen && !rst && st == IDLE && inst_valid;
    dau_en   = cen && !rst && st == EXEC && (!is_cond || cond_true);
    busy     = st != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      t_field   <= '0;
      f1_field  <= '0;
      f2_field  <= '0;
      s_field   <= 1'b0;
      d_field   <= 1'b0;
      c_field   <= '0;
      cond_true <= 1'b0;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      lfsr      <= LFSR_SEED;
    end else if (cen) begin
      st <= st_nx;
      if (st == IDLE && inst_valid) begin
        t_field  <= inst[15:11];
        d_field  <= inst[10];
        s_field  <= inst[9];
        f1_field <= inst[8:5];
        f2_field <= inst[8:5];
        c_field  <= inst[4:0];
      end
      if (st == DEC) cond_true <= is_cond ? cond_eval : 1'b1;
      if (lfsr_step) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      c0 <= c_wr[0] ? c_din : c0_inc ? c0 + 8'd1 : c0;
      c1 <= c_wr[1] ? c_din : (c1_inc || ifc_exec) ? c1 + 8'd1 : c1;
      if (ifc_exec) c2 <= c1;
    end
  end
endmodule

// File: tb/tb_jtdsp16_dau_ctrl.sv
// tb_jtdsp16_dau_ctrl: directed and randomized instruction sequences checked against a behavioural model
module tb_jtdsp16_dau_ctrl;
  logic rst, clk, cen, inst_valid, lmi, leq, llv, lmv;
  logic [15:0] inst;
  logic [1:0] c_wr;
  logic [7:0] c_din;
  logic inst_ack, busy, s_field, d_field, dau_en, cond_true;
  logic [4:0] t_field, c_field;
  logic [3:0] f1_field, f2_field;
  logic [7:0] c0, c1, c2;
  int n_vec = 0, n_err = 0;
  logic [7:0] m_c0, m_c1, m_c2;
  logic [15:0] m_l;
  jtdsp16_dau_ctrl #(.LFSR_SEED(16'h0001)) dut (
    .rst(rst), .clk(clk), .cen(cen), .inst_valid(inst_valid), .inst(inst),
    .lmi(lmi), .leq(leq), .llv(llv), .lmv(lmv), .c_wr(c_wr), .c_din(c_din),
    .inst_ack(inst_ack), .busy(busy), .t_field(t_field), .f1_field(f1_field),
    .f2_field(f2_field), .s_field(s_field), .d_field(d_field), .c_field(c_field),
    .dau_en(dau_en), .cond_true(cond_true), .c0(c0), .c1(c1), .c2(c2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit cond_of(input int con, input logic [3:0] f);
    bit mi, eq, lv, mv;
    {mi, eq, lv, mv} = f;
    case (con)
      0: return mi;        1: return !mi;
      2: return eq;        3: return !eq;
      4: return lv;        5: return !lv;
      6: return mv;        7: return !mv;
      8: return m_l[0];    9: return !m_l[0];
      10: return m_c0 < 8'h80;  11: return m_c0 >= 8'h80;
      12: return m_c1 < 8'h80;  13: return m_c1 >= 8'h80;
      14: return 1'b1;
      16: return !mi && !eq;
      17: return mi || eq;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [15:0] mk(input logic [4:0] t, input logic [4:0] con);
    logic [5:0] mid;
    mid = 6'($urandom);
    return {t, mid, con};
  endfunction
  task automatic model_reset();
    m_c0 = 8'h00; m_c1 = 8'h00; m_c2 = 8'h00; m_l = 16'h0001;
  endtask
  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, inst_ack, 0);
    chk({tag, "_en"}, dau_en, 0);
    chk({tag, "_cond"}, cond_true, 0);
    chk({tag, "_fields"}, {t_field, d_field, s_field, f1_field, c_field}, 0);
    chk({tag, "_f2"}, f2_field, 0);
    chk({tag, "_cnt"}, {c0, c1}, 0);
    chk({tag, "_c2"}, c2, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; inst_valid = 1'b1; inst = 16'hFFFF; c_wr = 2'b11;
    @(negedge clk);
    chk("rst_ack_gated", inst_ack, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; cen = 1'b1; inst_valid = 1'b0; c_wr = 2'b00;
    model_reset();
    chk_reset("reset");
    @(posedge clk); #1;
  endtask
  task automatic wr_c(input logic [1:0] sel, input logic [7:0] val);
    c_wr = sel; c_din = val; cen = 1'b1;
    @(posedge clk); #1;
    c_wr = 2'b00;
    if (sel[0]) m_c0 = val;
    if (sel[1]) m_c1 = val;
  endtask
  task automatic issue(input logic [15:0] i, input logic [3:0] fl, input logic [1:0] wr,
                       input logic [7:0] din, input int stall, input bit hold);
    bit ic, cv, en;
    int con;
    logic [4:0] t;
    t = i[15:11]; con = int'(i[4:0]);
    ic = (t == 5'h12) || (t == 5'h13);
    cen = 1'b1; inst_valid = 1'b1; inst = i;
    @(negedge clk);
    chk("idle_ack", inst_ack, 1);
    chk("idle_busy", busy, 0);
    chk("idle_en", dau_en, 0);
    @(posedge clk); #1;
    inst = 16'($urandom);
    {lmi, leq, llv, lmv} = fl;
    for (int k = 0; k < stall; k++) begin
      cen = 1'b0; c_wr = 2'b11; c_din = 8'($urandom);
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_strobes", {inst_ack, dau_en}, 0);
      chk("stall_cnt", {c0, c1}, {m_c0, m_c1});
      @(posedge clk); #1;
    end
    cen = 1'b1; c_wr = wr; c_din = din;
    @(negedge clk);
    chk("dec_busy", busy, 1);
    chk("dec_strobes", {inst_ack, dau_en}, 0);
    chk("dec_fields", {t_field, d_field, s_field, f1_field, c_field}, i);
    chk("dec_f2", f2_field, i[8:5]);
    cv = ic ? cond_of(con, fl) : 1'b1;
    if (ic && (con == 8 || con == 9)) m_l = {m_l[14:0], m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]};
    if (ic && (con == 10 || con == 11)) m_c0 = m_c0 + 8'd1;
    if (ic && (con == 12 || con == 13)) m_c1 = m_c1 + 8'd1;
    if (wr[0]) m_c0 = din;
    if (wr[1]) m_c1 = din;
    @(posedge clk); #1;
    c_wr = 2'b00; {lmi, leq, llv, lmv} = 4'($urandom);
    en = !ic || cv;
    @(negedge clk);
    chk("exec_cond", cond_true, cv);
    chk("exec_en", dau_en, en);
    chk("exec_busy", busy, 1);
    chk("exec_ack", inst_ack, 0);
    chk("exec_cnt", {c0, c1}, {m_c0, m_c1});
    if (t == 5'h13) begin
      m_c2 = m_c1;
      m_c1 = m_c1 + 8'd1;
    end
    @(posedge clk); #1;
    inst_valid = hold; inst = i;
    @(negedge clk);
    chk("post_ack", inst_ack, hold);
    chk("post_busy", busy, 0);
    chk("post_cnt", {c0, c1}, {m_c0, m_c1});
    chk("post_c2", c2, m_c2);
    chk("post_cond", cond_true, cv);
    inst_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [4:0] t, con;
    rst = 1'b1; cen = 1'b1; inst_valid = 1'b0; inst = '0;
    {lmi, leq, llv, lmv} = 4'b0000; c_wr = 2'b00; c_din = 8'h00;
    model_reset();
    do_reset();
    issue(16'h0000, 4'h0, 2'b00, 8'h00, 0, 1'b1);
    issue(16'h0000, 4'hF, 2'b00, 8'h00, 0, 1'b0);
    issue(mk(5'h12, 5'd2), 4'b0000, 2'b00, 8'h00, 0, 1'b0);
    issue(mk(5'h12, 5'd2), 4'b0100, 2'b00, 8'h00, 0, 1'b0);
    wr_c(2'b01, 8'hFF);
    issue(mk(5'h12, 5'd10), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    issue(mk(5'h12, 5'd10), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    chk("c0_after_two", c0, 8'h01);
    wr_c(2'b10, 8'h7F);
    issue(mk(5'h13, 5'd15), 4'hF, 2'b00, 8'h00, 0, 1'b0);
    chk("ifc_c1", c1, 8'h80);
    chk("ifc_c2", c2, 8'h7F);
    issue(mk(5'h12, 5'd12), 4'h0, 2'b10, 8'h42, 0, 1'b0);
    do_reset();
    issue(mk(5'h12, 5'd8), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    for (int k = 0; k < 3; k++) issue(mk(5'h12, 5'd14), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    issue(mk(5'h12, 5'd9), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    cen = 1'b0; inst_valid = 1'b1;
    @(negedge clk);
    chk("cen0_ack", inst_ack, 0);
    @(posedge clk); #1;
    cen = 1'b1; inst_valid = 1'b0;
    @(negedge clk);
    chk("cen0_idle", busy, 0);
    @(posedge clk); #1;
    issue(mk(5'h12, 5'd11), 4'h0, 2'b00, 8'h00, 5, 1'b0);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: t = 5'h12;
        1: t = 5'h13;
        default: t = 5'($urandom);
      endcase
      con = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 17));
      issue(mk(t, con), 4'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
            8'($urandom), ($urandom_range(0, 5) == 0) ? 2 : 0, 1'($urandom));
    end
    wr_c(2'b11, 8'h35);
    cen = 1'b1; inst_valid = 1'b1; inst = mk(5'h13, 5'd14);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_en", dau_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_reset("rst_exec");
    @(posedge clk); #1;
    issue(mk(5'h12, 5'd8), 4'h0, 2'b00, 8'h00, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jtdsp16_dau_ctrl.md
JTDSP16_DAU_CTRL -- requirements
Module: jtdsp16_dau_ctrl

Interface
REQ-001 Parameter LFSR_SEED, default 16'h0001, meaning reset value of the heads/tails pseudorandom register.
REQ-002 Port rst, input, 1, synchronous active-high reset.
REQ-003 Port clk, input, 1, single clock for the block.
REQ-004 Port cen, input, 1, clock enable; when low, all state holds and all strobes are low.
REQ-005 Port inst_valid, input, 1, instruction word present on inst.
REQ-006 Port inst, input, 16, DAU instruction: [15:11] T, [10] D, [9] S, [8:5] F1 (F2 when T=0x12/0x13), [4:0] CON.
REQ-007 Port lmi / leq / llv / lmv, input, 1 each, DAU flags: negative, zero, logical overflow, mathematical overflow.
REQ-008 Port c_wr, input, 2, bit0 writes c0, bit1 writes c1 from c_din.
REQ-009 Port c_din, input, 8, counter write data.
REQ-010 Port inst_ack, output, 1, instruction accepted this cycle.
REQ-011 Port busy, output, 1, controller not idle.
REQ-012 Port t_field / f1_field / f2_field / s_field / d_field / c_field, output, 5/4/4/1/1/5, latched decoded fields to the DAU.
REQ-013 Port dau_en, output, 1, one-cycle execute strobe to the DAU.
REQ-014 Port cond_true, output, 1, result of the condition evaluated for the current instruction.
REQ-015 Port c0 / c1 / c2, output, 8 each, counter registers.

Function
REQ-016 The FSM SHALL have states IDLE, DEC and EXEC; it advances only on cycles with cen=1.
REQ-017 IDLE: when inst_valid=1, it SHALL pulse inst_ack, latch all fields from inst and go to DEC. f1_field and f2_field both take inst[8:5].
REQ-018 DEC: it SHALL sample lmi/leq/llv/lmv, evaluate CON, register cond_true and go to EXEC; busy=1.
REQ-019 EXEC: it SHALL pulse dau_en and return to IDLE; busy=1. Fixed latency is accept -> dau_en two cen cycles later, so one instruction issues per three cen cycles.
REQ-020 For T other than 0x12/0x13, cond_true SHALL be forced to 1 and dau_en asserted unconditionally.
REQ-021 For T=0x12 or 0x13, dau_en SHALL be asserted only if cond_true=1.
REQ-022 CON codes: 0 mi=lmi; 1 pl=!lmi; 2 eq=leq; 3 ne=!leq; 4 lvs=llv; 5 lvc=!llv; 6 mvs=lmv; 7 mvc=!lmv; 8 heads; 9 tails; 10 c0ge; 11 c0lt; 12 c1ge; 13 c1lt; 14 true; 15 false; 16 gt=!lmi&!leq; 17 le=lmi|leq; 18-31 false.
REQ-023 c0ge/c0lt SHALL test the pre-increment c0 sign (ge: c0[7]=0); c0 SHALL increment by 1 in DEC. c1 codes behave the same way on c1.
REQ-024 Counters SHALL wrap in 8-bit two's complement (0x7F+1=0x80, 0xFF+1=0x00).
REQ-025 heads SHALL be LFSR[0]=1 and tails LFSR[0]=0. The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL shift one step in DEC only when CON is 8 or 9.
REQ-026 T=0x13 (ifc) in EXEC: c2 SHALL take c1 and c1 SHALL increment, regardless of cond_true.
REQ-027 A c_wr write SHALL take priority over any same-cycle increment of the same counter. It applies in any state when cen=1.
REQ-028 inst_valid SHALL be ignored while busy=1; inst_ack is never high while busy=1.
REQ-029 Tag REQ-029: the FSM SHALL never skip a state and never stall within DEC or EXEC other than on cen=0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear all field outputs, c0=c1=c2=0x00, LFSR=LFSR_SEED, inst_ack=dau_en=cond_true=busy=0. This applies independent of cen.
REQ-031 Reset in DEC or EXEC SHALL abort the instruction with no dau_en and no counter or LFSR update.

Verification
REQ-032 inst=0x0000 (T=0) with inst_valid held -> inst_ack at cycle 0, dau_en=1 and cond_true=1 at cycle 2, next inst_ack at cycle 3.
REQ-033 T=0x12, CON=2, leq=0 during DEC -> cond_true=0 and dau_en=0 in EXEC; with leq=1 -> dau_en=1.
REQ-034 c0 written 0xFF, then T=0x12 CON=10 -> cond_true=0, c0=0x00; repeat -> cond_true=1, c0=0x01.
REQ-035 c1=0x7F, T=0x13 CON=15 -> dau_en=0, c1 goes 0x7F -> 0x80 (no increment in DEC) and c2=0x7F.
REQ-036 Reset seed 0x0001, CON=8 -> cond_true=1 and LFSR advances once; CON=14 repeated -> LFSR unchanged.
REQ-037 cen=0 for 5 cycles during DEC -> no state change; rst pulse during EXEC -> dau_en stays 0, all outputs at reset values.
